// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the BytePipe register initiator.
//   BP_ADDR_W      - register address width carried in the command byte
//   BP_CMD_WR_BIT  - bit of the command byte that flags a write
//   bp_state_e     - initiator FSM states
//   timer_width()  - counter width able to hold a given cycle limit
package bp_pkg;

    localparam int BP_ADDR_W     = 7;
    localparam int BP_CMD_WR_BIT = 7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CMD  = 3'd1,
        ST_DATA = 3'd2,
        ST_WAIT = 3'd3,
        ST_RSP  = 3'd4
    } bp_state_e;

    // A limit of 0 still needs a 1-bit counter to stay a legal vector.
    function automatic int timer_width(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/bp_timer.sv
// bp_timer: response-wait down-counter with terminal-count compare.
//   i_clk, i_rst_n - clock, async active-low reset (count resets to 0)
//   i_clear        - reload the count with LIMIT
//   i_enable       - count down one step this cycle
//   o_expired      - high in the enabled cycle that completes LIMIT cycles
// LIMIT = 0 never expires.
module bp_timer
    import bp_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int            W    = timer_width(LIMIT);
    localparam logic [W-1:0]  LOAD = W'(LIMIT);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = LOAD;
        end else if (i_enable && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Loaded with LIMIT on entry, so the cycle holding 1 is the LIMIT-th one.
    assign o_expired = (LIMIT != 0) && i_enable && (count_q == W'(1));

endmodule

// File: rtl/bp_initiator.sv
// bp_initiator: turns register read/write requests into BytePipe command
// bytes, waits for the single response byte and reports it.
//   i_clk, i_rst_n, i_cg            - clock, async active-low reset, clock-gate enable
//   i_req_*  / o_req_ready          - request: wr, addr, data, check, expect
//   o_bp_data/o_bp_valid/i_bp_ready - bytes towards the responder
//   i_bp_data/i_bp_valid/o_bp_ready - bytes from the responder
//   o_rsp_* / i_rsp_ready           - response: data, mismatch, timeout
//   o_nMismatch                     - saturating mismatch count
//   o_unexpected                    - sticky: byte received outside WAIT
//
// state | meaning
// IDLE  | ready for a request
// CMD   | sending {wr,addr} command byte
// DATA  | sending write data byte
// WAIT  | waiting for the response byte or timeout
// RSP   | presenting the response until taken
module bp_initiator
    import bp_pkg::*;
#(
    parameter int TIMEOUT         = 255,
    parameter bit ZERO_ON_TIMEOUT = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cg,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_wr,
    input  logic [BP_ADDR_W-1:0] i_req_addr,
    input  logic [7:0]           i_req_data,
    input  logic                 i_req_check,
    input  logic [7:0]           i_req_expect,
    output logic [7:0]           o_bp_data,
    output logic                 o_bp_valid,
    input  logic                 i_bp_ready,
    input  logic [7:0]           i_bp_data,
    input  logic                 i_bp_valid,
    output logic                 o_bp_ready,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [7:0]           o_rsp_data,
    output logic                 o_rsp_mismatch,
    output logic                 o_rsp_timeout,
    output logic [7:0]           o_nMismatch,
    output logic                 o_unexpected
);

    bp_state_e state_q, state_d;

    logic                 wr_q, wr_d;
    logic [BP_ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]           data_q, data_d;
    logic                 check_q, check_d;
    logic [7:0]           expect_q, expect_d;
    logic [7:0]           rsp_data_q, rsp_data_d;
    logic                 mismatch_q, mismatch_d;
    logic                 timeout_q, timeout_d;
    logic [7:0]           nmis_q, nmis_d;
    logic                 unexp_q, unexp_d;

    logic       bp_ready;
    logic       byte_acc;
    logic       byte_mis;
    logic       tmr_expired;
    logic [7:0] cmd_byte;

    // Ready is held off only in RSP: the responder loops our ready back as
    // its own input ready, so dropping it earlier would stall our commands.
    assign bp_ready = (state_q != ST_RSP);
    assign byte_acc = i_bp_valid && bp_ready;
    assign byte_mis = check_q && (i_bp_data != expect_q);

    always_comb begin
        cmd_byte                  = '0;
        cmd_byte[BP_CMD_WR_BIT]   = wr_q;
        cmd_byte[BP_ADDR_W-1:0]   = addr_q;
    end

    bp_timer #(
        .LIMIT(TIMEOUT)
    ) u_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_cg && (state_q != ST_WAIT)),
        .i_enable  (i_cg && (state_q == ST_WAIT)),
        .o_expired (tmr_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else if (i_cg) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_req_valid) state_d = ST_CMD;
            ST_CMD:  if (i_bp_ready)  state_d = wr_q ? ST_DATA : ST_WAIT;
            ST_DATA: if (i_bp_ready)  state_d = ST_WAIT;
            // A byte in the expiry cycle still counts as a real response.
            ST_WAIT: if (byte_acc || tmr_expired) state_d = ST_RSP;
            ST_RSP:  if (i_rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_req_ready = (state_q == ST_IDLE);
        o_bp_valid  = (state_q == ST_CMD) || (state_q == ST_DATA);
        o_bp_ready  = bp_ready;
        o_rsp_valid = (state_q == ST_RSP);
        case (state_q)
            ST_CMD:  o_bp_data = cmd_byte;
            ST_DATA: o_bp_data = data_q;
            default: o_bp_data = 8'h00;
        endcase
    end

    always_comb begin
        wr_d       = wr_q;
        addr_d     = addr_q;
        data_d     = data_q;
        check_d    = check_q;
        expect_d   = expect_q;
        rsp_data_d = rsp_data_q;
        mismatch_d = mismatch_q;
        timeout_d  = timeout_q;
        nmis_d     = nmis_q;
        unexp_d    = unexp_q;

        if ((state_q == ST_IDLE) && i_req_valid) begin
            wr_d     = i_req_wr;
            addr_d   = i_req_addr;
            data_d   = i_req_data;
            check_d  = i_req_check;
            expect_d = i_req_expect;
        end

        if (state_q == ST_WAIT) begin
            if (byte_acc) begin
                rsp_data_d = i_bp_data;
                mismatch_d = byte_mis;
                timeout_d  = 1'b0;
                if (byte_mis && (nmis_q != 8'hFF)) begin
                    nmis_d = nmis_q + 8'd1;
                end
            end else if (tmr_expired) begin
                mismatch_d = 1'b0;
                timeout_d  = 1'b1;
                if (ZERO_ON_TIMEOUT) begin
                    rsp_data_d = 8'h00;
                end
            end
        end else if (byte_acc) begin
            unexp_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= 8'h00;
            check_q    <= 1'b0;
            expect_q   <= 8'h00;
            rsp_data_q <= 8'h00;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
            nmis_q     <= 8'h00;
            unexp_q    <= 1'b0;
        end else if (i_cg) begin
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            check_q    <= check_d;
            expect_q   <= expect_d;
            rsp_data_q <= rsp_data_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
            nmis_q     <= nmis_d;
            unexp_q    <= unexp_d;
        end
    end

    assign o_rsp_data     = rsp_data_q;
    assign o_rsp_mismatch = mismatch_q;
    assign o_rsp_timeout  = timeout_q;
    assign o_nMismatch    = nmis_q;
    assign o_unexpected   = unexp_q;

endmodule

// File: tb/tb_bp_initiator.sv
// tb_bp_initiator: directed and randomized transactions against a register
// memory responder model; checks command bytes, responses, flags and counts.
module tb_bp_initiator;

    localparam int TO = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_cg;
    logic       i_req_valid;
    logic       o_req_ready;
    logic       i_req_wr;
    logic [6:0] i_req_addr;
    logic [7:0] i_req_data;
    logic       i_req_check;
    logic [7:0] i_req_expect;
    logic [7:0] o_bp_data;
    logic       o_bp_valid;
    logic       i_bp_ready;
    logic [7:0] i_bp_data;
    logic       i_bp_valid;
    logic       o_bp_ready;
    logic       o_rsp_valid;
    logic       i_rsp_ready;
    logic [7:0] o_rsp_data;
    logic       o_rsp_mismatch;
    logic       o_rsp_timeout;
    logic [7:0] o_nMismatch;
    logic       o_unexpected;

    always #5 i_clk = ~i_clk;

    bp_initiator #(
        .TIMEOUT        (TO),
        .ZERO_ON_TIMEOUT(1'b1)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_cg          (i_cg),
        .i_req_valid   (i_req_valid),
        .o_req_ready   (o_req_ready),
        .i_req_wr      (i_req_wr),
        .i_req_addr    (i_req_addr),
        .i_req_data    (i_req_data),
        .i_req_check   (i_req_check),
        .i_req_expect  (i_req_expect),
        .o_bp_data     (o_bp_data),
        .o_bp_valid    (o_bp_valid),
        .i_bp_ready    (i_bp_ready),
        .i_bp_data     (i_bp_data),
        .i_bp_valid    (i_bp_valid),
        .o_bp_ready    (o_bp_ready),
        .o_rsp_valid   (o_rsp_valid),
        .i_rsp_ready   (i_rsp_ready),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_mismatch(o_rsp_mismatch),
        .o_rsp_timeout (o_rsp_timeout),
        .o_nMismatch   (o_nMismatch),
        .o_unexpected  (o_unexpected)
    );

    // Reference state: responder register memory and expected status.
    logic [7:0] mem [128];
    int         exp_nmis;
    bit         exp_unexp;
    int         n_tests;
    int         n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_req(input bit wr, input logic [6:0] addr, input logic [7:0] data,
                            input bit chk, input logic [7:0] expct);
        check("req_ready", o_req_ready, 1);
        i_req_valid  = 1'b1;
        i_req_wr     = wr;
        i_req_addr   = addr;
        i_req_data   = data;
        i_req_check  = chk;
        i_req_expect = expct;
        tick();
        i_req_valid  = 1'b0;
    endtask

    // Present one outgoing byte, optionally stalling ready / gating the clock.
    task automatic take_byte(input string tag, input logic [7:0] want, input int stall, input int cg_off);
        check({tag, "_valid"}, o_bp_valid, 1);
        check({tag, "_byte"}, o_bp_data, want);
        repeat (stall) begin
            tick();
            check({tag, "_hold_valid"}, o_bp_valid, 1);
            check({tag, "_hold_byte"}, o_bp_data, want);
        end
        i_bp_ready = 1'b1;
        if (cg_off > 0) begin
            i_cg = 1'b0;
            repeat (cg_off) begin
                tick();
                check({tag, "_cg_hold"}, o_bp_data, want);
            end
            i_cg = 1'b1;
        end
        tick();
        i_bp_ready = 1'b0;
    endtask

    task automatic txn(input bit wr, input logic [6:0] addr, input logic [7:0] data,
                       input bit chk, input logic [7:0] expct,
                       input int bp_stall, input int rsp_delay, input int rsp_stall, input int cg_off);
        logic [7:0] ret;
        bit         mis;
        ret = mem[addr];
        if (wr) mem[addr] = data;
        mis = chk && (ret != expct);
        if (mis && exp_nmis < 255) exp_nmis++;

        send_req(wr, addr, data, chk, expct);
        take_byte("cmd", {wr, addr}, bp_stall, cg_off);
        if (wr) take_byte("data", data, bp_stall, 0);
        repeat (rsp_delay) begin
            check("wait_no_rsp", o_rsp_valid, 0);
            tick();
        end
        i_bp_valid = 1'b1;
        i_bp_data  = ret;
        tick();
        i_bp_valid = 1'b0;
        check("rsp_valid", o_rsp_valid, 1);
        check("rsp_data", o_rsp_data, ret);
        check("rsp_mismatch", o_rsp_mismatch, mis);
        check("rsp_timeout", o_rsp_timeout, 0);
        check("nmismatch", o_nMismatch, exp_nmis);
        check("unexpected", o_unexpected, exp_unexp);
        repeat (rsp_stall) begin
            i_req_valid = 1'b1;
            tick();
            check("rsp_hold_valid", o_rsp_valid, 1);
            check("rsp_hold_data", o_rsp_data, ret);
            check("rsp_hold_mis", o_rsp_mismatch, mis);
            check("rsp_no_accept", o_req_ready, 0);
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        check("back_idle", o_req_ready, 1);
        check("rsp_dropped", o_rsp_valid, 0);
        check("bp_valid_idle", o_bp_valid, 0);
    endtask

    initial begin
        int         n;
        bit         rw;
        logic [6:0] ra;
        logic [7:0] rexp;
        n_tests = 0;
        n_fail  = 0;
        exp_nmis  = 0;
        exp_unexp = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;

        i_rst_n = 1'b1; i_cg = 1'b1; i_req_valid = 1'b0; i_req_wr = 1'b0;
        i_req_addr = '0; i_req_data = '0; i_req_check = 1'b0; i_req_expect = '0;
        i_bp_ready = 1'b0; i_bp_data = '0; i_bp_valid = 1'b0; i_rsp_ready = 1'b0;
        #2 i_rst_n = 1'b0;
        tick();
        tick();
        check("rst_req_ready", o_req_ready, 1);
        check("rst_bp_valid", o_bp_valid, 0);
        check("rst_rsp_valid", o_rsp_valid, 0);
        check("rst_rsp_data", o_rsp_data, 0);
        check("rst_flags", {o_rsp_mismatch, o_rsp_timeout, o_unexpected}, 0);
        check("rst_nmis", o_nMismatch, 0);
        i_rst_n = 1'b1;
        tick();

        // Write 0xA5 to 0x05, then read it back expecting 0x5A.
        txn(1'b1, 7'h05, 8'hA5, 1'b0, 8'h00, 0, 1, 0, 0);
        check("wr_prev_zero", o_rsp_data, 8'h00);
        txn(1'b0, 7'h05, 8'h00, 1'b1, 8'h5A, 0, 0, 0, 0);
        check("rd_value_a5", o_rsp_data, 8'hA5);
        check("rd_nmis_one", o_nMismatch, 8'd1);

        // Stalled bytes and a held response.
        txn(1'b1, 7'h12, 8'h3C, 1'b1, 8'h00, 3, 2, 5, 0);

        // Byte in the same cycle the timer would expire.
        txn(1'b0, 7'h12, 8'h00, 1'b1, 8'h3C, 0, TO - 1, 0, 0);

        // Clock gate low: nothing advances despite ready.
        txn(1'b0, 7'h05, 8'h00, 1'b0, 8'h00, 0, 1, 1, 3);

        // Silent responder.
        send_req(1'b0, 7'h05, 8'h00, 1'b1, 8'h77);
        take_byte("to_cmd", {1'b0, 7'h05}, 0, 0);
        n = 0;
        while (!o_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("timeout_latency", n, TO);
        check("timeout_flag", o_rsp_timeout, 1);
        check("timeout_mis", o_rsp_mismatch, 0);
        check("timeout_data", o_rsp_data, 0);
        check("timeout_nmis", o_nMismatch, exp_nmis);
        i_rsp_ready = 1'b1;
        tick();
        i_rsp_ready = 1'b0;
        check("timeout_idle", o_req_ready, 1);

        // Randomized traffic over a small address window.
        for (int k = 0; k < 24; k++) begin
            rw   = 1'($urandom_range(0, 1));
            ra   = 7'($urandom_range(0, 7));
            rexp = ($urandom_range(0, 1) == 1) ? mem[ra] : 8'($urandom);
            txn(rw, ra, 8'($urandom), 1'($urandom_range(0, 1)), rexp,
                $urandom_range(0, 2), $urandom_range(0, TO - 1), $urandom_range(0, 2), 0);
        end

        // Stray byte while idle.
        i_bp_valid = 1'b1;
        i_bp_data  = 8'h33;
        tick();
        i_bp_valid = 1'b0;
        exp_unexp  = 1'b1;
        check("unexp_set", o_unexpected, 1);
        txn(1'b0, 7'h05, 8'h00, 1'b0, 8'h00, 0, 0, 0, 0);
        check("unexp_sticky", o_unexpected, 1);

        // Drive the mismatch counter into saturation.
        for (int k = 0; k < 260; k++) begin
            txn(1'b0, 7'h00, 8'h00, 1'b1, mem[0] ^ 8'hFF, 0, 0, 0, 0);
        end
        check("nmis_saturated", o_nMismatch, 8'hFF);

        // Reset while waiting for a response.
        send_req(1'b0, 7'h01, 8'h00, 1'b0, 8'h00);
        take_byte("rst_cmd", {1'b0, 7'h01}, 0, 0);
        tick();
        #2 i_rst_n = 1'b0;
        #1;
        check("mid_rst_req_ready", o_req_ready, 1);
        check("mid_rst_rsp_valid", o_rsp_valid, 0);
        check("mid_rst_nmis", o_nMismatch, 0);
        check("mid_rst_unexp", o_unexpected, 0);
        exp_nmis  = 0;
        exp_unexp = 1'b0;
        tick();
        i_rst_n = 1'b1;
        check("post_rst_ready", o_req_ready, 1);
        tick();
        check("post_rst_flags", {o_rsp_valid, o_rsp_mismatch, o_rsp_timeout, o_unexpected}, 0);
        txn(1'b0, 7'h05, 8'h00, 1'b1, 8'h00, 1, 1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
